// File: rtl/serial_adder_driver.sv
// serial_adder_driver: takes a parallel operand pair, sends it LSB-first on the
// serial adder's vld/a/b/last bit-stream, collects the returned sum bits and
// offers the assembled sum to a parallel consumer.
module serial_adder_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             ser_en,
  output logic             ser_vld,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_last,
  input  logic             ser_sum,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_sum
);

  // A one-bit counter is still needed when WIDTH is 1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] res_next;
  logic            at_last;

  // Handshake flags come straight from the state register.
  assign in_rdy  = (state == IDLE);
  assign out_vld = (state == DONE);
  assign out_sum = res;

  // Serial side: bit valid only in SHIFT with permission; data forced low otherwise.
  assign at_last  = (cnt == CW'(WIDTH - 1));
  assign ser_vld  = (state == SHIFT) && ser_en;
  assign ser_a    = ser_vld && sh_a[0];
  assign ser_b    = ser_vld && sh_b[0];
  assign ser_last = ser_vld && at_last;

  // Result register shifted right with the new sum bit entering at the MSB.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a full default
    // first, so no path leaves it unassigned and no latch is inferred.
    res_next            = res >> 1;
    res_next[WIDTH-1]   = ser_sum;
  end

  // Control FSM with operand shift registers, bit counter and result register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the datapath registers are few and small, so they are cleared with the
    // control state; this keeps out_sum defined from reset onward.
    if (!rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here sees the
      // pre-edge values of the others regardless of statement order.
      unique case (state)
        IDLE: begin
          if (in_vld) begin
            sh_a  <= in_a;
            sh_b  <= in_b;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (ser_en) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            res  <= res_next;
            cnt  <= cnt + CW'(1);
            if (at_last) state <= DONE;
          end
        end
        DONE: begin
          if (out_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
